// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================
// pwm_pkg -- state encoding and command-word layout shared by the
// PWM generator and capture blocks.  Rev 1.0
// ============================================================
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  localparam int          DIR_BIT  = 15;
  localparam int          DUTY_MSB = 14;
  localparam logic [14:0] DUTY_SAT = 15'h7FFF;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================
// sync_edge -- 2-flop synchronizer with rise/fall detection on the
// synchronized level.  Rev 1.0
// ============================================================
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       meta_q, meta_d;
  logic       lvl_q, lvl_d;
  logic       prev_q, prev_d;
  logic [2:0] prime_q, prime_d;

  always_comb begin
    meta_d  = din;
    lvl_d   = meta_q;
    prev_d  = lvl_q;
    prime_d = {prime_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      prime_q <= 3'b000;
    end else begin
      meta_q  <= meta_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

  // Edges are gated until the pipeline holds real samples, so a line that
  // is already high when reset releases does not look like a fresh rise.
  assign level = lvl_q;
  assign rise  = prime_q[2] & lvl_q & ~prev_q;
  assign fall  = prime_q[2] & ~lvl_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================
// pwm_capture -- measures PWM high time and period, rebuilds the
// {dir, duty} command word, flags static lines and glitches.  Rev 1.0
// ============================================================
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MIN_PERIOD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spd_in,
  input  logic             dir_in,
  output logic [15:0]      data_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stale,
  output logic             glitch
);

  localparam int               IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_PER   = CNT_W'(MIN_PERIOD);

  logic spd_lvl, spd_rise, spd_fall;
  logic dir_lvl, unused_dir_rise, unused_dir_fall;

  sync_edge u_spd_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spd_in),
    .level (spd_lvl),
    .rise  (spd_rise),
    .fall  (spd_fall)
  );

  sync_edge u_dir_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (dir_in),
    .level (dir_lvl),
    .rise  (unused_dir_rise),
    .fall  (unused_dir_fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic             armed_q, armed_d;
  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             glitch_q, glitch_d;
  logic             stale_q, stale_d;
  logic             timeout_hit;
  logic [31:0]      hi_wide;
  logic [DUTY_MSB:0] duty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign hi_wide = 32'(hi_cnt_q);
  assign duty    = (hi_wide > 32'(DUTY_SAT)) ? DUTY_SAT : hi_wide[DUTY_MSB:0];

  always_comb begin
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    per_cnt_d   = per_cnt_q;
    idle_d      = idle_q;
    armed_d     = armed_q;
    data_d      = data_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    glitch_d    = 1'b0;
    stale_d     = stale_q;
    timeout_hit = 1'b0;

    // An edge always wins over a timeout landing in the same cycle.
    if (spd_rise || spd_fall) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d      = IDLE_MAX;
      timeout_hit = 1'b1;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_ONE;
    end

    case (state_q)
      ST_SYNC: begin
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        if (spd_rise) begin
          state_d   = ST_HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end
      end
      ST_HIGH: begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (spd_fall) begin
          state_d = ST_LOW;
        end else begin
          hi_cnt_d = sat_inc(hi_cnt_q);
        end
      end
      ST_LOW: begin
        if (spd_rise) begin
          if (per_cnt_q >= MIN_PER) begin
            data_d[DIR_BIT]      = dir_lvl;
            data_d[DUTY_MSB:0]   = duty;
            period_d             = per_cnt_q;
            valid_d              = 1'b1;
            stale_d              = 1'b0;
            armed_d              = 1'b1;
          end else begin
            glitch_d = 1'b1;
          end
          state_d   = ST_HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // A static line always resynchronizes, but reports only once per
    // published period so a dead line does not keep strobing valid.
    if (timeout_hit) begin
      state_d   = ST_SYNC;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      stale_d   = 1'b1;
      if (armed_q) begin
        data_d[DIR_BIT]    = dir_lvl;
        data_d[DUTY_MSB:0] = spd_lvl ? DUTY_SAT : '0;
        period_d           = '0;
        valid_d            = 1'b1;
        armed_d            = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
      idle_q    <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
      stale_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      per_cnt_q <= per_cnt_d;
      idle_q    <= idle_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      glitch_q  <= glitch_d;
      stale_q   <= stale_d;
    end
  end

  assign data_out   = data_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign glitch     = glitch_q;
  assign stale      = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================
// tb_pwm_capture -- randomized and directed PWM stimulus checked against
// an interval-based reference model.  Rev 1.0
// ============================================================
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int TIMEOUT_CYC = 4096;
  localparam int LONG_TO     = 65535;
  localparam int MIN_PERIOD  = 4;
  localparam int K_PUB       = 0;
  localparam int K_TO        = 1;
  localparam int K_GLITCH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spd_in = 1'b0;
  logic        dir_in = 1'b0;
  logic [15:0] data_out, period_out, data_l, period_l;
  logic        valid, stale, glitch, valid_l, unused_stale_l, unused_glitch_l;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .TIMEOUT_CYC(TIMEOUT_CYC), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk(clk), .rst(rst), .spd_in(spd_in), .dir_in(dir_in),
    .data_out(data_out), .period_out(period_out),
    .valid(valid), .stale(stale), .glitch(glitch)
  );

  pwm_capture #(.CNT_W(16), .TIMEOUT_CYC(LONG_TO), .MIN_PERIOD(MIN_PERIOD)) dut_long (
    .clk(clk), .rst(rst), .spd_in(spd_in), .dir_in(dir_in),
    .data_out(data_l), .period_out(period_l),
    .valid(valid_l), .stale(unused_stale_l), .glitch(unused_glitch_l)
  );

  typedef struct {
    int kind;
    int data;
    int period;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, last_valid_cyc = 0;
  int   l_total = 0;
  logic [15:0] l_data = '0, l_per = '0;

  // Reference model state: the line is described as a sequence of
  // constant-level segments; periods come from rise-to-rise distances.
  int t_now = 0, t_rise = 0, h_len = 0, idle_len = 0;
  int last_data = 0, last_period = 0;
  bit session = 0, armed = 0, rise_pub = 0, to_done = 0, from_rise = 0;
  bit cur_lvl = 0, cur_dir = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (valid_l === 1'b1) begin
      l_total++;
      l_data = data_l;
      l_per  = period_l;
    end
    if (valid === 1'b1 || glitch === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'({valid, glitch}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_GLITCH) begin
          check_eq("glitch_strobe", 32'(glitch), 32'd1);
          check_eq("glitch_no_valid", 32'(valid), 32'd0);
          check_eq("glitch_data_hold", 32'(data_out), e.data);
          check_eq("glitch_period_hold", 32'(period_out), e.period);
        end else begin
          check_eq(e.kind == K_TO ? "to_valid" : "pub_valid", 32'(valid), 32'd1);
          check_eq(e.kind == K_TO ? "to_data" : "pub_data", 32'(data_out), e.data);
          check_eq(e.kind == K_TO ? "to_period" : "pub_period", 32'(period_out), e.period);
          check_eq(e.kind == K_TO ? "to_stale" : "pub_stale", 32'(stale), 32'(e.kind == K_TO));
          if (e.gap != 0) check_eq("valid_spacing", cyc - last_valid_cyc, e.gap);
        end
      end
    end
    if (valid === 1'b1) last_valid_cyc = cyc;
  endtask

  task automatic drive_seg(input bit lvl, input bit d, input int n);
    exp_t e;
    int   p;
    spd_in = lvl;
    dir_in = d;
    if (lvl != cur_lvl) begin
      idle_len  = 0;
      to_done   = 0;
      from_rise = lvl;
      if (lvl) begin
        if (session) begin
          p = t_now - t_rise;
          if (p > 65535) p = 65535;
          if (p >= MIN_PERIOD) begin
            e.kind   = K_PUB;
            e.data   = (int'(d) << 15) | ((h_len > 32767) ? 32767 : h_len);
            e.period = p;
            e.gap    = rise_pub ? p : 0;
            last_data = e.data; last_period = p; armed = 1; rise_pub = 1;
          end else begin
            e.kind = K_GLITCH; e.data = last_data; e.period = last_period; e.gap = 0;
            rise_pub = 0;
          end
          exp_q.push_back(e);
        end else begin
          rise_pub = 0;
        end
        session = 1;
        t_rise  = t_now;
      end else begin
        h_len = t_now - t_rise;
      end
    end
    cur_lvl = lvl;
    cur_dir = d;
    idle_len += n;
    if (idle_len > TIMEOUT_CYC && !to_done) begin
      to_done = 1;
      session = 0;
      if (armed) begin
        e.kind   = K_TO;
        e.data   = (int'(d) << 15) | (lvl ? 32767 : 0);
        e.period = 0;
        e.gap    = (from_rise && rise_pub) ? TIMEOUT_CYC : 0;
        last_data = e.data; last_period = 0; armed = 0;
        exp_q.push_back(e);
      end
      rise_pub = 0;
    end
    repeat (n) tick();
    t_now += n;
  endtask

  task automatic pulse_pair(input int h, input int l, input bit d);
    drive_seg(1'b1, cur_dir, h);
    drive_seg(1'b0, d, l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(data_out), 32'd0);
    check_eq({tag, "_period"}, 32'(period_out), 32'd0);
    check_eq({tag, "_stale"}, 32'(stale), 32'd1);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_glitch"}, 32'(glitch), 32'd0);
  endtask

  initial begin
    int nvalid;
    int l0;
    int h, l;

    // Power-on reset with the line low.
    repeat (3) tick();
    check_reset_outputs("rst_init");
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      tick();
      if (valid === 1'b1) nvalid++;
    end
    check_eq("no_valid_after_rst", nvalid, 0);
    t_now = 0;

    // 25 high / 75 low, dir=1.
    for (int i = 0; i < 6; i++) pulse_pair(25, 75, 1'b1);

    // Randomized high/low times and direction changes mid-period.
    for (int i = 0; i < 40; i++) begin
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 60));
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 60));
      pulse_pair(h, l, 1'($urandom_range(0, 1)));
    end

    // Period-2 glitch train, then the MIN_PERIOD boundary (3 vs 4).
    for (int i = 0; i < 5; i++) pulse_pair(1, 1, 1'b0);
    pulse_pair(1, 2, 1'b1);
    pulse_pair(2, 2, 1'b1);
    pulse_pair(25, 75, 1'b0);

    // Static-high timeout after a valid period, then recovery at 10/10.
    drive_seg(1'b1, 1'b0, 10);
    drive_seg(1'b0, 1'b0, 10);
    drive_seg(1'b1, 1'b0, 5000);
    drive_seg(1'b0, 1'b0, 10);
    for (int i = 0; i < 3; i++) pulse_pair(10, 10, 1'b0);

    // Reset in the middle of a high phase.
    drive_seg(1'b1, 1'b1, 10);
    check_eq("q_empty_before_rst", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    t_now += 1;
    session = 0; armed = 0; rise_pub = 0; to_done = 0; from_rise = 0;
    idle_len = 0; last_data = 0; last_period = 0;
    drive_seg(1'b1, 1'b1, 10);
    drive_seg(1'b0, 1'b1, 15);
    for (int i = 0; i < 3; i++) pulse_pair(15, 15, 1'b1);

    // Long high time: saturated duty on the long-timeout instance.
    drive_seg(1'b1, 1'b1, 40000);
    drive_seg(1'b0, 1'b1, 5000);
    l0 = l_total;
    drive_seg(1'b1, 1'b1, 30);
    check_eq("long_valid_count", l_total - l0, 1);
    check_eq("long_data", 32'(l_data), (1 << 15) | ((40000 > 32767) ? 32767 : 40000));
    check_eq("long_period", 32'(l_per), 40000 + 5000);
    drive_seg(1'b0, 1'b1, 20);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
